// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared constants for the AES round sequencer.
//   - key length encodings (key_len input)
//   - FSM state encodings for aes_round_ctrl
//   - lookup functions Nk, Nr and expanded-word count per key length
package aes_ctrl_pkg;

    localparam logic [1:0] KL_128 = 2'd0;
    localparam logic [1:0] KL_192 = 2'd1;
    localparam logic [1:0] KL_256 = 2'd2;
    localparam logic [1:0] KL_RSV = 2'd3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_KEYEXP = 3'd1;
    localparam logic [2:0] ST_INIT   = 3'd2;
    localparam logic [2:0] ST_ROUND  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd12;
            KL_256:  return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] words_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 6'd52;
            KL_256:  return 6'd60;
            default: return 6'd44;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_ctrl_kx.sv
// aes_kx_counter: key-expansion word counter.
//   clk, rst    : clock, synchronous active-high reset
//   load        : start a new expansion at i = nk_in (captures Nk)
//   step        : advance to the next word
//   nk_in       : Nk for the run being loaded
//   widx        : word index i
//   rcon        : Rcon index i/Nk
//   rot         : i mod Nk == 0
//   sub         : Nk == 8 and i mod 8 == 4
// i mod Nk and i/Nk are tracked incrementally by a phase counter that wraps
// at Nk and bumps rcon on each wrap, so no divider is needed.
module aes_kx_counter
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic [3:0] nk_in,
    output logic [5:0] widx,
    output logic [3:0] rcon,
    output logic       rot,
    output logic       sub
);

    logic [3:0] nk_q;
    logic [3:0] phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            nk_q  <= '0;
            widx  <= '0;
            phase <= '0;
            rcon  <= '0;
        end else if (load) begin
            nk_q  <= nk_in;
            widx  <= {2'b00, nk_in};
            phase <= '0;
            rcon  <= 4'd1;
        end else if (step) begin
            widx <= widx + 6'd1;
            if (phase == nk_q - 4'd1) begin
                phase <= '0;
                rcon  <= rcon + 4'd1;
            end else begin
                phase <= phase + 4'd1;
            end
        end
    end

    assign rot = (phase == 4'd0);
    assign sub = (nk_q == 4'd8) && (phase == 4'd4);

endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative sequencer for the shared AES datapath.
// Runs key expansion one word per cycle, then the initial AddRoundKey and
// Nr rounds (forward or inverse), then pulses done.
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request, sampled only in IDLE
//   key_len    : 0/1/2 = AES-128/192/256, 3 = reserved (err)
//   decrypt    : direction, latched at start
//   key_new    : key rewritten since last run (key cache only)
//   busy       : run in progress (cycle after start through done)
//   done       : one-cycle completion pulse
//   err        : one-cycle pulse the cycle after a start with key_len = 3
//   kx_*       : key-expansion controls (enable, word index, rot, sub, rcon)
//   rnd_en, rk_idx, rnd_first, rnd_last, inv : round unit controls
// Build option: AES_KEY_CACHE_EN skips key expansion when the key and
// key length are unchanged since the last completed expansion.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] key_len,
    input  logic       decrypt,
    input  logic       key_new,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       kx_en,
    output logic [5:0] kx_widx,
    output logic       kx_rot,
    output logic       kx_sub,
    output logic [3:0] kx_rcon,
    output logic       rnd_en,
    output logic [3:0] rk_idx,
    output logic       rnd_first,
    output logic       rnd_last,
    output logic       inv
);

    logic [2:0] state;
    logic [1:0] kl;
    logic       inv_q;
    logic [3:0] rnd;
    logic       err_q;
    logic [3:0] nr;
    logic [5:0] last_word;
    logic       accept;
    logic       bad;
    logic       cache_hit;
    logic       kx_load;
    logic       kx_last;
    logic [5:0] widx;
    logic [3:0] rcon;
    logic       rot;
    logic       sub;

    assign nr        = nr_of(kl);
    assign last_word = words_of(kl) - 6'd1;
    assign accept    = (state == ST_IDLE) && start && (key_len != KL_RSV);
    assign bad       = (state == ST_IDLE) && start && (key_len == KL_RSV);
    assign kx_load   = accept && !cache_hit;
    assign kx_last   = (state == ST_KEYEXP) && (widx == last_word);

`ifdef AES_KEY_CACHE_EN
    logic       cache_valid;
    logic [1:0] cache_kl;

    assign cache_hit = cache_valid && !key_new && (key_len == cache_kl);

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            cache_kl    <= '0;
        end else if (bad) begin
            cache_valid <= 1'b0;
        end else if (kx_last) begin
            cache_valid <= 1'b1;
            cache_kl    <= kl;
        end
    end
`else
    logic unused_key_new;
    assign unused_key_new = key_new;
    assign cache_hit      = 1'b0;
`endif

    aes_kx_counter u_kx (
        .clk   (clk),
        .rst   (rst),
        .load  (kx_load),
        .step  (state == ST_KEYEXP),
        .nk_in (nk_of(key_len)),
        .widx  (widx),
        .rcon  (rcon),
        .rot   (rot),
        .sub   (sub)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            kl    <= '0;
            inv_q <= 1'b0;
            rnd   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= bad;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        kl    <= key_len;
                        inv_q <= decrypt;
                        state <= cache_hit ? ST_INIT : ST_KEYEXP;
                    end
                end
                ST_KEYEXP: begin
                    if (kx_last) state <= ST_INIT;
                end
                ST_INIT: begin
                    rnd   <= 4'd1;
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (rnd == nr) state <= ST_DONE;
                    else           rnd   <= rnd + 4'd1;
                end
                ST_DONE: begin
                    rnd   <= '0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign err       = err_q;
    assign kx_en     = (state == ST_KEYEXP);
    assign kx_widx   = kx_en ? widx : '0;
    assign kx_rot    = kx_en && rot;
    assign kx_sub    = kx_en && sub;
    assign kx_rcon   = kx_en ? rcon : '0;
    assign rnd_first = (state == ST_INIT);
    assign rnd_en    = rnd_first || (state == ST_ROUND);
    assign rnd_last  = (state == ST_ROUND) && (rnd == nr);
    assign inv       = inv_q && busy;

    always_comb begin
        rk_idx = '0;
        if (state == ST_INIT)       rk_idx = inv_q ? nr : 4'd0;
        else if (state == ST_ROUND) rk_idx = inv_q ? (nr - rnd) : rnd;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative sequencer for the AES datapath. It accepts a start request with key length (128/192/256) and direction (encrypt or decrypt). It first steps the key-expansion unit one word per cycle, then steps the cipher or inverse-cipher round unit through AddRoundKey and Nr rounds, and reports completion. It sits between the top-level key-size/mode selection and the shared KeyExpansion/Cipher/invCipher datapath, so one datapath instance serves all three key sizes.

## Interface
- No parameters. Nk, Nr and word counts are fixed constants in the package.
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- key_len  in  2  0=AES-128, 1=AES-192, 2=AES-256, 3=reserved
- decrypt  in  1  0=encrypt, 1=decrypt; latched at start
- key_new  in  1  key register was rewritten since the last run; used only with AES_KEY_CACHE_EN
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle pulse in the DONE state
- err  out  1  one-cycle pulse when a start arrives with key_len=3
- kx_en  out  1  key-expansion word write enable
- kx_widx  out  6  expanded word index i (Nk..4(Nr+1)-1)
- kx_rot  out  1  i mod Nk == 0 (RotWord+SubWord+Rcon)
- kx_sub  out  1  Nk==8 and i mod 8 == 4 (SubWord only)
- kx_rcon  out  4  Rcon index i/Nk (1..10)
- rnd_en  out  1  round unit update enable
- rk_idx  out  4  round-key index applied this cycle
- rnd_first  out  1  initial AddRoundKey only (loads state)
- rnd_last  out  1  final round; MixColumns/InvMixColumns bypassed
- inv  out  1  latched decrypt; selects the inverse datapath

## Operation
- States: IDLE, KEYEXP, INIT, ROUND, DONE.
- IDLE:
  - start with key_len<3 → latch key_len and decrypt, then go to KEYEXP with i=Nk.
  - start with key_len=3 → err pulse; stay in IDLE.
- KEYEXP:
  - kx_en=1 and i increments each cycle.
  - kx_rot, kx_sub and kx_rcon are combinational from i and the latched Nk, using a mod-Nk sub-counter (no divider).
  - After i=4(Nr+1)-1 → INIT.
  - Word counts: 40 / 46 / 52.
- INIT:
  - rnd_en=1, rnd_first=1.
  - rk_idx=0 when encrypting, Nr when decrypting.
  - Next state: ROUND with round counter r=1.
- ROUND:
  - rnd_en=1 every cycle.
  - rk_idx=r when encrypting, Nr−r when decrypting.
  - rnd_last=1 when r=Nr; then go to DONE. Otherwise r increments.
- DONE: done=1 for one cycle → IDLE.
- All non-enable index outputs are 0 outside their active states.
- start outside IDLE is ignored and no error is raised.
- key_len and decrypt changes after acceptance have no effect until the next start.

## Timing
- Reset value of every output is 0. State resets to IDLE, counters to 0, and the cache valid flag is cleared.
- Start accepted at cycle T. done asserts at:
  - T+52 for AES-128
  - T+60 for AES-192
  - T+68 for AES-256
  - These equal 1 + words + 1 + Nr.
- busy is high during cycles T+1 through the done cycle inclusive.
- A start is accepted again in the cycle after done.
- rst asserted mid-run takes effect at the next edge. Outputs are 0 the following cycle and no done is produced.
- If start and rst are asserted together, rst wins.

## Configuration
- AES_KEY_CACHE_EN defined:
  - A valid flag and the last key_len are held.
  - If a start arrives with key_new=0, the same key_len as the last run and valid=1, KEYEXP is skipped and the block goes IDLE→INIT.
  - done then asserts at T+12/14/16.
  - valid is set on completing KEYEXP and cleared by rst or by a key_len=3 error.
- AES_KEY_CACHE_EN undefined:
  - key_new is ignored and KEYEXP always runs.

## Structure
- Package aes_ctrl_pkg holds:
  - state enum
  - key_len encodings
  - functions or lookup constants for NK(key_len) = 4/6/8, NR(key_len) = 10/12/14 and WORDS(key_len) = 44/52/60
- One sub-module, aes_kx_counter, provides:
  - the word index i
  - the mod-Nk phase counter
  - the Rcon index
  - outputs kx_rot and kx_sub

## Test plan
- AES-128 encrypt: start at T, key_len=0, decrypt=0 → kx_widx runs 4..43; kx_rot at 4,8,…,40 with kx_rcon 1..10; rk_idx 0,1..10; rnd_last only at 10; done at T+52.
- AES-256 decrypt: key_len=2, decrypt=1 → kx_sub at i=12,20,…,52; rk_idx 14,13..0; inv=1 throughout; done at T+68.
- AES-192: key_len=2'b01 → kx_rot at i=6,12,…,48 (kx_rcon 1..8); 12 rounds; done at T+60.
- Error and ignore: key_len=3 → err pulse, busy stays 0; start pulsed mid-run → no restart, done timing unchanged.
- Reset mid-ROUND at round 5 → next cycle all outputs 0, state IDLE; a fresh start completes normally.
- With AES_KEY_CACHE_EN: two back-to-back AES-128 runs with key_new=0 → second run has no kx_en and done at T+12. A third run with key_new=1 → full T+52.
